// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush controller for the 5-stage pipeline: load-use interlock,
// taken-branch squash with programmable penalty, and data-memory wait with timeout.
module pipeline_hazard_ctrl #(
  parameter int REG_NUM_WIDTH = 5,
  parameter int BR_PENALTY    = 1,
  parameter int MEM_TIMEOUT   = 15
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     id_valid,
  input  logic [REG_NUM_WIDTH-1:0] id_rs,
  input  logic [REG_NUM_WIDTH-1:0] id_rt,
  input  logic                     id_uses_rt,
  input  logic                     ex_is_load,
  input  logic                     ex_wr_en,
  input  logic [REG_NUM_WIDTH-1:0] ex_dst,
  input  logic                     mem_br_taken,
  input  logic                     dmem_req,
  input  logic                     dmem_ack,
  output logic                     pc_stall,
  output logic                     ifid_stall,
  output logic                     idex_stall,
  output logic                     exmem_stall,
  output logic                     ifid_flush,
  output logic                     idex_flush,
  output logic                     exmem_flush,
  output logic                     memwb_bubble,
  output logic                     mem_timeout,
  output logic [1:0]               state,
  output logic [15:0]              stall_cycles
);

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    BR_FLUSH = 2'd2
  } state_e;

  localparam logic [7:0] TIMEOUT_CNT = 8'(MEM_TIMEOUT);
  localparam logic [2:0] PENALTY_CNT = 3'(BR_PENALTY);

  state_e      state_q, state_d;
  logic [7:0]  wait_cnt_q, wait_cnt_d;
  logic [2:0]  flush_cnt_q, flush_cnt_d;
  logic        mem_timeout_q, mem_timeout_d;
  logic [15:0] stall_cycles_q, stall_cycles_d;

  logic load_use, mem_busy;
  logic stall_pc, stall_ifid, stall_idex, stall_exmem;
  logic flush_ifid, flush_idex, flush_exmem, bubble;

  assign load_use = id_valid & ex_is_load & ex_wr_en & (ex_dst != '0) &
                    ((ex_dst == id_rs) | (id_uses_rt & (ex_dst == id_rt)));
  assign mem_busy = dmem_req & ~dmem_ack;

  always_comb begin
    state_d       = state_q;
    wait_cnt_d    = wait_cnt_q;
    flush_cnt_d   = flush_cnt_q;
    mem_timeout_d = mem_timeout_q;
    stall_pc      = 1'b0;
    stall_ifid    = 1'b0;
    stall_idex    = 1'b0;
    stall_exmem   = 1'b0;
    flush_ifid    = 1'b0;
    flush_idex    = 1'b0;
    flush_exmem   = 1'b0;
    bubble        = 1'b0;

    case (state_q)
      MEM_WAIT: begin
        if (dmem_ack) begin
          state_d = RUN;
        end else begin
          {stall_pc, stall_ifid, stall_idex, stall_exmem, bubble} = '1;
          if (wait_cnt_q == TIMEOUT_CNT) begin
            state_d       = RUN;
            mem_timeout_d = 1'b1;
          end else begin
            wait_cnt_d = wait_cnt_q + 8'd1;
          end
        end
      end
      // RUN and BR_FLUSH share the memory/branch priority; BR_FLUSH only adds the shadow flush
      default: begin
        if (mem_busy) begin
          {stall_pc, stall_ifid, stall_idex, stall_exmem, bubble} = '1;
          wait_cnt_d  = 8'd1;
          flush_cnt_d = '0;
          state_d     = MEM_WAIT;
        end else if (mem_br_taken) begin
          {flush_ifid, flush_idex, flush_exmem} = '1;
          if (BR_PENALTY > 0) begin
            flush_cnt_d = PENALTY_CNT;
            state_d     = BR_FLUSH;
          end else begin
            state_d = RUN;
          end
        end else if (state_q == BR_FLUSH) begin
          {flush_ifid, flush_idex} = '1;
          flush_cnt_d = flush_cnt_q - 3'd1;
          if (flush_cnt_q == 3'd1) begin
            state_d = RUN;
          end
        end else if (load_use) begin
          stall_pc   = 1'b1;
          stall_ifid = 1'b1;
          flush_idex = 1'b1;
        end
      end
    endcase

    stall_cycles_d = stall_cycles_q;
    if (pc_stall && (stall_cycles_q != '1)) begin
      stall_cycles_d = stall_cycles_q + 16'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= RUN;
      wait_cnt_q     <= '0;
      flush_cnt_q    <= '0;
      mem_timeout_q  <= 1'b0;
      stall_cycles_q <= '0;
    end else begin
      state_q        <= state_d;
      wait_cnt_q     <= wait_cnt_d;
      flush_cnt_q    <= flush_cnt_d;
      mem_timeout_q  <= mem_timeout_d;
      stall_cycles_q <= stall_cycles_d;
    end
  end

  // Flush takes precedence over stall on the same register; everything is forced low in reset
  assign pc_stall     = ~rst & stall_pc;
  assign ifid_stall   = ~rst & stall_ifid & ~flush_ifid;
  assign idex_stall   = ~rst & stall_idex & ~flush_idex;
  assign exmem_stall  = ~rst & stall_exmem & ~flush_exmem;
  assign ifid_flush   = ~rst & flush_ifid;
  assign idex_flush   = ~rst & flush_idex;
  assign exmem_flush  = ~rst & flush_exmem;
  assign memwb_bubble = ~rst & bubble;
  assign mem_timeout  = mem_timeout_q;
  assign state        = state_q;
  assign stall_cycles = stall_cycles_q;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Bench for pipeline_hazard_ctrl: directed scenarios with literal expectations,
// then randomized traffic checked every cycle against a behavioural model.
module tb_pipeline_hazard_ctrl;

  localparam int RW  = 5;
  localparam int BRP = 2;
  localparam int MTO = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          id_valid, id_uses_rt, ex_is_load, ex_wr_en;
  logic [RW-1:0] id_rs, id_rt, ex_dst;
  logic          mem_br_taken, dmem_req, dmem_ack;
  logic          pc_stall, ifid_stall, idex_stall, exmem_stall;
  logic          ifid_flush, idex_flush, exmem_flush, memwb_bubble;
  logic          mem_timeout;
  logic [1:0]    state;
  logic [15:0]   stall_cycles;

  int n_cmp = 0;
  int n_bad = 0;

  // Model: m_age>0 means an access is outstanding (cycles spent waiting so far),
  // m_left>0 means that many branch-shadow cycles remain.
  int m_age, m_left, m_sc;
  bit m_to;
  int n_age, n_left;
  bit n_to;
  bit e_ps, e_is, e_xs, e_ms, e_if, e_xf, e_mf, e_bb;

  pipeline_hazard_ctrl #(
    .REG_NUM_WIDTH(RW),
    .BR_PENALTY   (BRP),
    .MEM_TIMEOUT  (MTO)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .id_valid     (id_valid),
    .id_rs        (id_rs),
    .id_rt        (id_rt),
    .id_uses_rt   (id_uses_rt),
    .ex_is_load   (ex_is_load),
    .ex_wr_en     (ex_wr_en),
    .ex_dst       (ex_dst),
    .mem_br_taken (mem_br_taken),
    .dmem_req     (dmem_req),
    .dmem_ack     (dmem_ack),
    .pc_stall     (pc_stall),
    .ifid_stall   (ifid_stall),
    .idex_stall   (idex_stall),
    .exmem_stall  (exmem_stall),
    .ifid_flush   (ifid_flush),
    .idex_flush   (idex_flush),
    .exmem_flush  (exmem_flush),
    .memwb_bubble (memwb_bubble),
    .mem_timeout  (mem_timeout),
    .state        (state),
    .stall_cycles (stall_cycles)
  );

  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s @%0t: got %0h expected %0h", nm, $time, act, exp);
    end
  endtask

  task automatic idle();
    id_valid = 0; id_uses_rt = 0; ex_is_load = 0; ex_wr_en = 0;
    id_rs = '0; id_rt = '0; ex_dst = '0;
    mem_br_taken = 0; dmem_req = 0; dmem_ack = 0;
  endtask

  // Evaluate the model for the current inputs and compare every output.
  task automatic cmp();
    bit lu, busy;
    int exp_state;
    logic [7:0] exp_ctl, act_ctl;
    if (rst) begin
      m_age = 0; m_left = 0; m_to = 0; m_sc = 0;
    end
    exp_state = (m_age > 0) ? 1 : (m_left > 0) ? 2 : 0;
    {e_ps, e_is, e_xs, e_ms, e_if, e_xf, e_mf, e_bb} = '0;
    n_age = m_age; n_left = m_left; n_to = m_to;
    lu = id_valid && ex_is_load && ex_wr_en && (ex_dst != 0) &&
         ((ex_dst == id_rs) || (id_uses_rt && (ex_dst == id_rt)));
    busy = dmem_req && !dmem_ack;
    if (!rst) begin
      if (m_age > 0) begin
        if (dmem_ack) n_age = 0;
        else begin
          {e_ps, e_is, e_xs, e_ms, e_bb} = '1;
          if (m_age == MTO) begin n_age = 0; n_to = 1; end
          else n_age = m_age + 1;
        end
      end else if (busy) begin
        {e_ps, e_is, e_xs, e_ms, e_bb} = '1;
        n_age = 1; n_left = 0;
      end else if (mem_br_taken) begin
        {e_if, e_xf, e_mf} = '1;
        n_left = BRP;
      end else if (m_left > 0) begin
        {e_if, e_xf} = '1;
        n_left = m_left - 1;
      end else if (lu) begin
        e_ps = 1; e_is = 1; e_xf = 1;
      end
    end
    exp_ctl = {e_ps, e_is, e_xs, e_ms, e_if, e_xf, e_mf, e_bb};
    act_ctl = {pc_stall, ifid_stall, idex_stall, exmem_stall,
               ifid_flush, idex_flush, exmem_flush, memwb_bubble};
    check("ctl", 32'(act_ctl), 32'(exp_ctl));
    check("state", 32'(state), exp_state);
    check("timeout", 32'(mem_timeout), 32'(m_to));
    check("stall_cycles", 32'(stall_cycles), m_sc);
  endtask

  task automatic settle();
    #1 cmp();
  endtask

  task automatic advance();
    @(posedge clk);
    if (!rst) begin
      m_age = n_age; m_left = n_left; m_to = n_to;
      if (e_ps && m_sc < 65535) m_sc++;
    end
    @(negedge clk);
  endtask

  initial begin
    m_age = 0; m_left = 0; m_sc = 0; m_to = 0;
    rst = 1; idle();
    @(negedge clk);
    settle();
    check("rst_state", 32'(state), 0);
    check("rst_sc", 32'(stall_cycles), 0);
    check("rst_ps", 32'(pc_stall), 0);
    advance();
    settle(); advance();
    rst = 0;

    // load-use on rs
    idle(); id_valid = 1; ex_is_load = 1; ex_wr_en = 1; ex_dst = 5'd8; id_rs = 5'd8;
    settle();
    check("lu_pc", 32'(pc_stall), 1);
    check("lu_ifid", 32'(ifid_stall), 1);
    check("lu_idexf", 32'(idex_flush), 1);
    advance();
    idle(); settle();
    check("lu_end", 32'(pc_stall), 0);
    check("lu_sc", 32'(stall_cycles), 1);
    advance();

    // r0 and rt gating
    idle(); id_valid = 1; ex_is_load = 1; ex_wr_en = 1; ex_dst = '0; id_rs = '0;
    settle(); check("r0", 32'(pc_stall), 0); advance();
    ex_dst = 5'd9; id_rs = 5'd1; id_rt = 5'd9; id_uses_rt = 0;
    settle(); check("rt_off", 32'(pc_stall), 0); advance();
    id_uses_rt = 1;
    settle(); check("rt_on", 32'(pc_stall), 1); advance();

    // taken branch, penalty 2
    idle(); mem_br_taken = 1;
    settle(); check("br0_mf", 32'(exmem_flush), 1); check("br0_if", 32'(ifid_flush), 1); advance();
    idle();
    settle(); check("br1_state", 32'(state), 2); check("br1_mf", 32'(exmem_flush), 0);
    check("br1_if", 32'(ifid_flush), 1); advance();
    settle(); check("br2_state", 32'(state), 2); check("br2_xf", 32'(idex_flush), 1); advance();
    settle(); check("br3_state", 32'(state), 0); check("br3_if", 32'(ifid_flush), 0); advance();

    // memory wait with ack on the 4th cycle, from a fresh reset
    rst = 1; idle(); settle(); advance(); rst = 0;
    dmem_req = 1;
    for (int i = 0; i < 3; i++) begin
      settle(); check("mw_bub", 32'(memwb_bubble), 1); check("mw_ms", 32'(exmem_stall), 1); advance();
    end
    dmem_ack = 1;
    settle(); check("mw_ack_ps", 32'(pc_stall), 0); check("mw_ack_state", 32'(state), 1); advance();
    idle();
    settle(); check("mw_done_state", 32'(state), 0); check("mw_sc", 32'(stall_cycles), 3); advance();

    // timeout after MTO waiting cycles
    dmem_req = 1; dmem_ack = 0;
    for (int i = 0; i < 5; i++) begin
      settle(); check("to_ps", 32'(pc_stall), 1); check("to_flag0", 32'(mem_timeout), 0); advance();
    end
    idle();
    settle(); check("to_flag1", 32'(mem_timeout), 1); check("to_state", 32'(state), 0);
    check("to_ps0", 32'(pc_stall), 0); advance();
    for (int i = 0; i < 3; i++) begin settle(); advance(); end
    settle(); check("to_sticky", 32'(mem_timeout), 1); check("to_sc", 32'(stall_cycles), 8); advance();

    // reset in the middle of a wait
    dmem_req = 1;
    settle(); advance();
    settle(); advance();
    rst = 1;
    settle();
    check("rm_ps", 32'(pc_stall), 0); check("rm_bub", 32'(memwb_bubble), 0);
    check("rm_state", 32'(state), 0); check("rm_to", 32'(mem_timeout), 0);
    check("rm_sc", 32'(stall_cycles), 0);
    advance();
    rst = 0; idle(); id_valid = 1; ex_is_load = 1; ex_wr_en = 1; ex_dst = 5'd3; id_rt = 5'd3; id_uses_rt = 1;
    settle(); check("rm_after", 32'(pc_stall), 1); advance();

    // randomized traffic
    for (int c = 0; c < 4000; c++) begin
      rst          = ($urandom_range(0, 255) == 0);
      id_valid     = ($urandom_range(0, 3) != 0);
      id_rs        = 5'($urandom_range(0, 3));
      id_rt        = 5'($urandom_range(0, 3));
      id_uses_rt   = ($urandom_range(0, 1) != 0);
      ex_is_load   = ($urandom_range(0, 2) == 0);
      ex_wr_en     = ($urandom_range(0, 3) != 0);
      ex_dst       = 5'($urandom_range(0, 3));
      mem_br_taken = ($urandom_range(0, 7) == 0);
      dmem_req     = ($urandom_range(0, 3) == 0);
      dmem_ack     = ($urandom_range(0, 4) == 0);
      settle();
      advance();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
